// File: rtl/booth_app_mult_pkg.sv
// Purpose : shared types and helpers for the approximate radix-4 Booth multiplier.
// Contents: Booth digit control encoding, named digit constants, truncation mask helper.
// Users   : booth_r4_encoder (digit decode) and booth_app_mult (pp generation).
package booth_app_mult_pkg;

    // Control word for one Booth digit. Magnitude is selected by one/two
    // (mutually exclusive), neg requests two's-complement negation of that
    // magnitude. A zero digit never sets neg, so no stray +1 is injected.
    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_ctl_t;

    localparam booth_ctl_t BOOTH_ZERO = '{neg: 1'b0, one: 1'b0, two: 1'b0};
    localparam booth_ctl_t BOOTH_POS1 = '{neg: 1'b0, one: 1'b1, two: 1'b0};
    localparam booth_ctl_t BOOTH_POS2 = '{neg: 1'b0, one: 1'b0, two: 1'b1};
    localparam booth_ctl_t BOOTH_NEG1 = '{neg: 1'b1, one: 1'b1, two: 1'b0};
    localparam booth_ctl_t BOOTH_NEG2 = '{neg: 1'b1, one: 1'b0, two: 1'b1};

    // Upper bound on product width supported by the mask helper.
    localparam int MAX_PROD_W = 128;

    // Keep-mask for a partial product: ones in every column at or above
    // 'trunc', zeros in the discarded low columns. Callers cast the result
    // down to their own product width.
    function automatic logic [MAX_PROD_W-1:0] trunc_mask(input int trunc);
        logic [MAX_PROD_W-1:0] m;
        m = '1;
        if (trunc >= MAX_PROD_W) begin
            m = '0;
        end else if (trunc > 0) begin
            m = m << trunc;
        end
        return m;
    endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Purpose : radix-4 Booth recoder for one multiplier triplet (b[2i+1], b[2i], b[2i-1]).
// Ports   : triplet in (3 bits), ctl out ({neg, one, two} digit controls).
// Timing  : purely combinational, no state and no flow control.
module booth_r4_encoder
    import booth_app_mult_pkg::*;
(
    input  logic [2:0] triplet,
    output booth_ctl_t ctl
);

    always_comb begin
        ctl = BOOTH_ZERO;
        case (triplet)
            3'b000:  ctl = BOOTH_ZERO;
            3'b001:  ctl = BOOTH_POS1;
            3'b010:  ctl = BOOTH_POS1;
            3'b011:  ctl = BOOTH_POS2;
            3'b100:  ctl = BOOTH_NEG2;
            3'b101:  ctl = BOOTH_NEG1;
            3'b110:  ctl = BOOTH_NEG1;
            3'b111:  ctl = BOOTH_ZERO;
            default: ctl = BOOTH_ZERO;
        endcase
    end

endmodule

// File: rtl/booth_app_mult.sv
// Purpose : signed radix-4 Booth multiplier, low TRUNC columns of every partial product dropped.
// Ports   : clk, rst_n (sync, active-low), in_valid/input_A/input_B in; out_valid/C out.
// Timing  : one-cycle latency, one result per cycle, never stalls (no backpressure).
module booth_app_mult
    import booth_app_mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TRUNC = WIDTH / 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     input_A,
    input  logic [WIDTH-1:0]     input_B,
    output logic                 out_valid,
    output logic [2*WIDTH-1:0]   C
);

    localparam int PW  = 2 * WIDTH;   // product width
    localparam int NPP = WIDTH / 2;   // number of Booth digits / partial products

    // Columns that survive truncation. TRUNC=0 keeps everything (exact),
    // TRUNC=2*WIDTH keeps nothing.
    localparam logic [PW-1:0] KEEP_MASK = PW'(trunc_mask(TRUNC));

    generate
        if ((WIDTH < 4) || ((WIDTH % 2) != 0) || (TRUNC < 0) || (TRUNC > 2 * WIDTH)
            || (PW > MAX_PROD_W)) begin : g_bad_param
            $error("booth_app_mult: illegal WIDTH/TRUNC combination");
        end
    endgenerate

    // Multiplier with the implicit b[-1]=0 appended below the LSB, so triplet
    // i is simply b_ext[2i+2 : 2i].
    logic [WIDTH:0] b_ext;
    assign b_ext = {input_B, 1'b0};

    // Multiplicand sign-extended to the full product width. Doubling it in
    // PW bits cannot overflow, which is what lets -2 * (most negative A) work.
    logic [PW-1:0] a_ext;
    assign a_ext = {{WIDTH{input_A[WIDTH-1]}}, input_A};

    booth_ctl_t     ctl      [NPP];
    logic [PW-1:0]  pp_trunc [NPP];

    generate
        for (genvar g = 0; g < NPP; g++) begin : g_pp
            logic [PW-1:0] mag;
            logic [PW-1:0] pp_signed;

            booth_r4_encoder u_enc (
                .triplet (b_ext[2*g+2 : 2*g]),
                .ctl     (ctl[g])
            );

            always_comb begin
                mag = '0;
                if (ctl[g].two) begin
                    mag = a_ext << 1;
                end else if (ctl[g].one) begin
                    mag = a_ext;
                end
                // Full invert-plus-one negation happens before truncation, so
                // the +1 of a negated pp is discarded whenever it lands in a
                // dropped column; this yields a true floor of each pp.
                pp_signed = ctl[g].neg ? (~mag + PW'(1)) : mag;
            end

            // Weight by 4^g, then clear the discarded low columns.
            assign pp_trunc[g] = (pp_signed << (2 * g)) & KEEP_MASK;
        end
    endgenerate

    // Accumulate all truncated partial products modulo 2^PW.
    logic [PW-1:0] pp_sum;

    always_comb begin
        pp_sum = '0;
        for (int i = 0; i < NPP; i++) begin
            pp_sum = pp_sum + pp_trunc[i];
        end
    end

    // Single output register. C only updates on an accepted operand pair so
    // it holds the last result while out_valid is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            C         <= '0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            C         <= pp_sum;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_booth_app_mult.sv
// Purpose : self-checking bench for booth_app_mult (approximate TRUNC=4 and exact TRUNC=0 instances).
// Latency : both instances expected one cycle after each accepted operand pair.
// Flow    : inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_booth_app_mult;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic signed [7:0]  A;
    logic signed [7:0]  B;
    logic               out_valid;
    logic signed [15:0] C;
    logic               out_valid0;
    logic signed [15:0] C0;

    int tests_run = 0;
    int tests_failed = 0;

    booth_app_mult #(.WIDTH(8), .TRUNC(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .input_A   (A),
        .input_B   (B),
        .out_valid (out_valid),
        .C         (C)
    );

    booth_app_mult #(.WIDTH(8), .TRUNC(0)) dut_exact (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .input_A   (A),
        .input_B   (B),
        .out_valid (out_valid0),
        .C         (C0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: Booth digit value d_i = -2*b[2i+1] + b[2i] + b[2i-1],
    // pp_i = d_i * A * 4^i, each pp floored to a multiple of 2^t, then summed.
    function automatic longint approx(input longint a, input logic [7:0] b, input int t);
        logic [8:0] bx;
        longint s;
        longint d;
        longint pp;
        bx = {b, 1'b0};
        s = 0;
        for (int i = 0; i < 4; i++) begin
            d  = -2 * longint'(bx[2*i+2]) + longint'(bx[2*i+1]) + longint'(bx[2*i]);
            pp = d * a * (longint'(1) << (2 * i));
            s  = s + ((pp >>> t) <<< t);
        end
        return s;
    endfunction

    // Behavioural model of the registered outputs.
    logic signed [15:0] m_c;
    logic signed [15:0] m_c0;
    logic               m_v;
    longint             m_prod;
    bit                 rst_seen = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_c = 16'sd0;
            m_c0 = 16'sd0;
            m_v = 1'b0;
            rst_seen = 1'b1;
        end else if (in_valid) begin
            m_prod = longint'(A) * longint'(B);
            m_c    = 16'(approx(longint'(A), B, 4));
            m_c0   = 16'(m_prod);
            m_v    = 1'b1;
        end else begin
            m_v = 1'b0;
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (rst_seen) begin
            check("out_valid", 64'(out_valid), 64'(m_v));
            check("out_valid_exact", 64'(out_valid0), 64'(m_v));
            check("C_approx", 64'(C), 64'(m_c));
            check("C_exact", 64'(C0), 64'(m_c0));
            if (m_v && rst_n) begin
                check("err_bound", 64'((longint'(C) - m_prod >= -60) && (longint'(C) - m_prod <= 0)), 64'(1));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    // Directed vectors (TRUNC=4) with hand-computed results.
    localparam int NDIR = 7;
    int dir_a   [NDIR] = '{124, -1,  1, 5,   0, -128,    127};
    int dir_b   [NDIR] = '{ 73,  1, -1, 3, -77, -128,   -128};
    int dir_exp [NDIR] = '{9040, -16, -16, 0, 0, 16384, -16256};

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b1;
        A = 8'sd124;
        B = 8'sd73;

        // Reset beats in_valid.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_C", 64'(C), 64'sd0);
        check("reset_valid", 64'(out_valid), 64'd0);
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("idle_after_reset_valid", 64'(out_valid), 64'd0);

        for (int k = 0; k < NDIR; k++) begin
            @(posedge clk);
            #1;
            A = 8'(dir_a[k]);
            B = 8'(dir_b[k]);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            @(negedge clk);
            check($sformatf("dir%0d_C(%0d*%0d)", k, dir_a[k], dir_b[k]), 64'(C), 64'(dir_exp[k]));
            check($sformatf("dir%0d_model", k), 64'(m_c), 64'(dir_exp[k]));
            check($sformatf("dir%0d_valid", k), 64'(out_valid), 64'd1);
            check($sformatf("dir%0d_exact", k), 64'(C0), 64'(dir_a[k] * dir_b[k]));
        end

        // Back-to-back stream then idle.
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        A = 8'sd124; B = 8'sd73;
        @(posedge clk);
        #1;
        A = 8'sd5; B = 8'sd3;
        @(negedge clk);
        check("pipe0_C", 64'(C), 64'sd9040);
        check("pipe0_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        A = -8'sd1; B = 8'sd1;
        @(negedge clk);
        check("pipe1_C", 64'(C), 64'sd0);
        check("pipe1_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = 8'sd99; B = -8'sd45;
        @(negedge clk);
        check("pipe2_C", 64'(C), -64'sd16);
        check("pipe2_valid", 64'(out_valid), 64'd1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("pipe_hold_C", 64'(C), -64'sd16);
            check("pipe_hold_valid", 64'(out_valid), 64'd0);
        end

        // Random stream: exact instance vs A*B, approximate vs model and error bound.
        for (int k = 0; k < 1000; k++) begin
            @(posedge clk);
            #1;
            A = 8'($urandom);
            B = 8'($urandom);
            in_valid = ($urandom_range(0, 9) != 0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;

        // Reset while an operation is in flight drops it.
        in_valid = 1'b1;
        A = 8'sd127; B = 8'sd127;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("midreset_C", 64'(C), 64'sd0);
        check("midreset_valid", 64'(out_valid), 64'd0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/booth_app_mult.md
Name:
booth_app_mult

Overview:
- Signed radix-4 Booth multiplier with approximate (truncated) partial-product accumulation, for the approximate-arithmetic datapath.
- Operands are two's-complement. Partial-product bits in the TRUNC least-significant columns are discarded before summation, which trades accuracy for adder area.
- Single registered output stage: one-cycle latency with a valid strobe.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 4.
- TRUNC, WIDTH/2, number of low product columns discarded from every partial product; legal range 0..2*WIDTH. TRUNC=0 gives an exact product.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, reset; synchronous, active-low.
- in_valid, input, 1, operands valid this cycle.
- input_A, input, WIDTH, signed multiplicand.
- input_B, input, WIDTH, signed multiplier (Booth-recoded).
- out_valid, output, 1, C holds a new result.
- C, output, 2*WIDTH, signed approximate product.

Behaviour:
- Clocking and reset:
  - Reset: one clock, synchronous, active-low. On a rising edge with rst_n=0, C is set to 0 and out_valid to 0.
  - Reset overrides in_valid; an operation in flight is dropped.
- Capture and latency:
  - On a rising edge with rst_n=1 and in_valid=1, C is loaded with f(input_A, input_B) and out_valid is set to 1. Latency is exactly 1 cycle.
  - With in_valid=0, out_valid is set to 0 and C holds its previous value.
  - Back-to-back in_valid gives one result per cycle. No stall or backpressure.
- Booth recoding:
  - b[-1] = 0. For i in 0..WIDTH/2-1, digit d_i in {-2,-1,0,+1,+2} comes from the triplet (b[2i+1], b[2i], b[2i-1]).
  - Mapping: 000/111 -> 0; 001/010 -> +1; 011 -> +2; 100 -> -2; 101/110 -> -1.
- Partial products:
  - pp_i = d_i * A * 4^i, computed as a 2*WIDTH-bit two's-complement value: sign-extended, negation by invert plus add-one.
  - Approximation: in each pp_i, force bits [TRUNC-1:0] to 0. This is a floor to a multiple of 2^TRUNC, and it includes the +1 carry of negated pps falling in those columns.
- Accumulation and range:
  - C = sum of all truncated pp_i, modulo 2^(2*WIDTH).
  - No overflow is possible for the exact case. Result error is within [-(WIDTH/2)*(2^TRUNC - 1), 0].
  - Extreme operands (A = B = -2^(WIDTH-1)) must work; d = -2 times the most negative A fits in 2*WIDTH bits.
- The combinational path is input -> register only. Inputs are not registered before the multiply.

Decomposition:
- Shared package:
  - Booth digit encoding constants (zero, pos1, pos2, neg1, neg2) as a 3-bit one-hot/sign typedef.
  - A function computing the truncation mask from TRUNC.
- One natural sub-module, booth_r4_encoder: maps a 3-bit triplet to {neg, one, two} controls.
  - Instantiate it WIDTH/2 times.
  - The partial-product generation, truncation and adder tree stay in the top module.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, A=124, B=73 -> C=0, out_valid=0. Release rst_n -> first result appears 1 cycle after the next in_valid edge.
- Default params (WIDTH=8, TRUNC=4), A=124, B=73:
  - Digits are +1, -2, +1, +1; pps are 112, -992, 1984, 7936.
  - Required C=9040, one cycle after in_valid (exact product is 9052).
- Sign and truncation (WIDTH=8, TRUNC=4):
  - A=-1, B=1 -> C=-16.
  - A=1, B=-1 -> C=-16.
  - A=5, B=3 -> C=0.
  - A=0, B=-77 -> C=0.
- Corner (WIDTH=8, TRUNC=4): A=-128, B=-128 -> C=16384; A=127, B=-128 -> C=-16256. Neither loses accuracy.
- Exact mode: TRUNC=0, random 1000 pairs -> C equals A*B exactly. TRUNC=4: 0 >= C - A*B >= -60 for all pairs.
- Pipeline:
  - Stream 3 back-to-back valid pairs (124,73), (5,3), (-1,1), then drop in_valid.
  - Required C sequence 9040, 0, -16, with out_valid high 3 cycles and then low.
  - C stays at -16 while out_valid is low.
